// File: rtl/zx_ula_pkg.sv
// Shared constants for the ZX ULA glue core: frame timing defaults, fixed RAM banks,
// I/O port numbers and the RAM page decode helper.
package zx_ula_pkg;

    localparam int H_TSTATES_DEF = 224;
    localparam int V_LINES_DEF   = 320;
    localparam int INT_LINE_DEF  = 239;
    localparam int INT_LEN_DEF   = 32;

    localparam logic [4:0]  BANK_SCREEN    = 5'd5;
    localparam logic [4:0]  BANK_MID       = 5'd2;

    localparam logic [7:0]  PORT_JOY       = 8'h1F;
    localparam logic [7:0]  PORT_SPI_DATA  = 8'h57;
    localparam logic [7:0]  PORT_SPI_CTRL  = 8'h77;
    localparam logic [7:0]  PORT_MAGIC_OFF = 8'hF7;
    localparam logic [15:0] NMI_VECTOR     = 16'h0066;

    // Upper CPU address segment to 5-bit SRAM page; segment 0 is ROM and never reaches SRAM.
    function automatic logic [4:0] ram_page(input logic [1:0] seg, input logic [4:0] bank_sel);
        case (seg)
            2'b01:   ram_page = BANK_SCREEN;
            2'b10:   ram_page = BANK_MID;
            default: ram_page = bank_sel;
        endcase
    endfunction

endpackage

// File: rtl/zx_spi_byte.sv
// SPI mode-0 byte engine: MSB first, sck = clk/2, one byte per 16 clocks.
module zx_spi_byte (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  logic [7:0] tx_i,
    input  logic       miso_i,
    output logic       busy_o,
    output logic [7:0] rx_o,
    output logic       sck_o,
    output logic       mosi_o
);

    logic [3:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       sck_q, sck_d;
    logic       mosi_q, mosi_d;
    logic [6:0] tx_sh_q, tx_sh_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic [7:0] rx_q, rx_d;

    // Shift sequencing: sample MISO on the rising sck phase, advance MOSI on the falling one.
    always_comb begin
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        tx_sh_d = tx_sh_q;
        rx_sh_d = rx_sh_q;
        rx_d    = rx_q;
        if (busy_q) begin
            cnt_d = cnt_q + 4'd1;
            if (!sck_q) begin
                sck_d   = 1'b1;
                rx_sh_d = {rx_sh_q[6:0], miso_i};
            end else begin
                sck_d   = 1'b0;
                mosi_d  = tx_sh_q[6];
                tx_sh_d = {tx_sh_q[5:0], 1'b0};
                if (cnt_q == 4'd15) begin
                    busy_d = 1'b0;
                    rx_d   = rx_sh_q;
                    mosi_d = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
        end else if (start_i) begin
            busy_d  = 1'b1;
            cnt_d   = 4'd0;
            sck_d   = 1'b0;
            mosi_d  = tx_i[7];
            tx_sh_d = tx_i[6:0];
        end else begin
            busy_d = 1'b0;
        end
    end

    // Engine state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b1;
            tx_sh_q <= 7'd0;
            rx_sh_q <= 8'd0;
            rx_q    <= 8'd0;
        end else begin
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            tx_sh_q <= tx_sh_d;
            rx_sh_q <= rx_sh_d;
            rx_q    <= rx_d;
        end
    end

    assign busy_o = busy_q;
    assign rx_o   = rx_q;
    assign sck_o  = sck_q;
    assign mosi_o = mosi_q;

endmodule

// File: rtl/zx_ula_core.sv
// ZX Spectrum 128/512K ULA glue: CPU clock, frame INT, 7FFD paging, SRAM/ROM bus,
// I/O ports FE/1F/7FFD/57/77/F7, magic NMI button and SD-card SPI.
module zx_ula_core
    import zx_ula_pkg::*;
#(
    parameter int H_TSTATES = H_TSTATES_DEF,
    parameter int V_LINES   = V_LINES_DEF,
    parameter int INT_LINE  = INT_LINE_DEF,
    parameter int INT_LEN   = INT_LEN_DEF
) (
    input  logic        clk28,
    input  logic        rst_n,
    output logic        clkcpu,
    input  logic [15:0] xa,
    inout  wire  [7:0]  xd,
    input  logic        n_rd,
    input  logic        n_wr,
    input  logic        n_iorqge,
    input  logic        n_mreq,
    input  logic        n_m1,
    input  logic        n_rfsh,
    output logic        n_romcs,
    output logic [17:14] ra,
    output logic [18:0] va,
    inout  wire  [7:0]  vd,
    output logic        n_vrd,
    output logic        n_vwr,
    output logic        n_int,
    inout  wire         n_nmi,
    input  logic        n_magic,
    input  logic        tape_in,
    input  logic [4:0]  kd,
    input  logic        n_joy_b2,
    input  logic        sd_cd,
    output logic        sd_mosi,
    input  logic        sd_miso,
    output logic        sd_sck,
    output logic        sd_n_cs
);

    logic [2:0] div_q;
    logic [8:0] hc_q, hc_d, vc_q, vc_d;
    logic       n_int_q;

    // T-state and line counters advance on the last clk28 of each CPU clock period.
    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (div_q == 3'd7) begin
            if (hc_q == 9'(H_TSTATES - 1)) begin
                hc_d = 9'd0;
                vc_d = (vc_q == 9'(V_LINES - 1)) ? 9'd0 : vc_q + 9'd1;
            end else begin
                hc_d = hc_q + 9'd1;
            end
        end else begin
            hc_d = hc_q;
        end
    end

    // Divider, raster counters and INT, decoded from next state so INT aligns with the counters.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= 3'd0;
            hc_q    <= 9'd0;
            vc_q    <= 9'd0;
            n_int_q <= 1'b1;
        end else begin
            div_q   <= div_q + 3'd1;
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            n_int_q <= ~((vc_d == 9'(INT_LINE)) && (hc_d < 9'(INT_LEN)));
        end
    end

    assign clkcpu = div_q[2];
    assign n_int  = n_int_q;

    logic [4:0] bank_q;
    logic       rom_q, lock_q, magic_map_q, sd_n_cs_q, io_wr_q;
    logic       mreq_s, rom_s;

    assign mreq_s  = ~n_mreq & n_rfsh;
    assign rom_s   = (xa[15:14] == 2'b00);
    assign n_romcs = ~(mreq_s & ~n_rd & rom_s);
    assign n_vrd   = ~(mreq_s & ~n_rd & ~rom_s);
    assign n_vwr   = ~(mreq_s & ~n_wr & ~rom_s);
    assign va      = {ram_page(xa[15:14], bank_q), xa[13:0]};
    assign ra      = {2'b00, magic_map_q, rom_q};
    assign vd      = n_vwr ? 8'hzz : xd;

    logic       io_s, io_wr_s, wr_stb_s, io_rd_s, io_hit_s;
    logic [7:0] io_data_s;
    logic       spi_busy_s;
    logic [7:0] spi_rx_s;

    assign io_s     = ~n_iorqge & n_m1;
    assign io_wr_s  = io_s & ~n_wr;
    assign wr_stb_s = io_wr_s & ~io_wr_q;
    assign io_rd_s  = io_s & ~n_rd;

    // I/O read multiplexer; unclaimed ports leave the CPU bus floating.
    always_comb begin
        io_hit_s  = 1'b1;
        io_data_s = 8'h00;
        if (!xa[0]) begin
            io_data_s = {1'b1, tape_in, 1'b1, kd};
        end else if (xa[7:0] == PORT_JOY) begin
            io_data_s = {2'b00, ~n_joy_b2, 5'b00000};
        end else if (xa[7:0] == PORT_SPI_DATA) begin
            io_data_s = spi_rx_s;
        end else if (xa[7:0] == PORT_SPI_CTRL) begin
            io_data_s = {6'b000000, spi_busy_s, ~sd_cd};
        end else begin
            io_hit_s = 1'b0;
        end
    end

    logic xd_ram_s, xd_io_s;
    assign xd_ram_s = ~n_vrd & ~n_rd;
    assign xd_io_s  = io_rd_s & io_hit_s;
    assign xd       = xd_ram_s ? vd : (xd_io_s ? io_data_s : 8'hzz);

    logic p7ffd_wr_s, spi_start_s, cs_wr_s, magic_off_s;
    assign p7ffd_wr_s  = wr_stb_s & ~xa[15] & ~xa[1] & ~lock_q;
    assign spi_start_s = wr_stb_s & (xa[7:0] == PORT_SPI_DATA);
    assign cs_wr_s     = wr_stb_s & (xa[7:0] == PORT_SPI_CTRL);
    assign magic_off_s = wr_stb_s & (xa[7:0] == PORT_MAGIC_OFF);

    logic [2:0] magic_sync_q;
    logic       nmi_q, nmi_d, magic_map_d, magic_fall_s, nmi_fetch_s;

    assign magic_fall_s = magic_sync_q[2] & ~magic_sync_q[1];
    assign nmi_fetch_s  = ~n_m1 & ~n_mreq & (xa == NMI_VECTOR);

    // NMI holds until the CPU fetches the vector; that fetch also maps the magic ROM.
    always_comb begin
        magic_map_d = magic_off_s ? 1'b0 : magic_map_q;
        if (nmi_q) begin
            if (nmi_fetch_s) begin
                nmi_d       = 1'b0;
                magic_map_d = 1'b1;
            end else begin
                nmi_d = 1'b1;
            end
        end else if (magic_fall_s && !magic_map_q) begin
            nmi_d = 1'b1;
        end else begin
            nmi_d = 1'b0;
        end
    end

    // Port latches, write-edge tracking and magic-button synchroniser.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            io_wr_q      <= 1'b0;
            bank_q       <= 5'd0;
            rom_q        <= 1'b0;
            lock_q       <= 1'b0;
            sd_n_cs_q    <= 1'b1;
            magic_sync_q <= 3'b111;
            nmi_q        <= 1'b0;
            magic_map_q  <= 1'b0;
        end else begin
            io_wr_q      <= io_wr_s;
            magic_sync_q <= {magic_sync_q[1:0], n_magic};
            nmi_q        <= nmi_d;
            magic_map_q  <= magic_map_d;
            if (p7ffd_wr_s) begin
                bank_q <= {xd[7:6], xd[2:0]};
                rom_q  <= xd[4];
                lock_q <= xd[5];
            end
            if (cs_wr_s) begin
                sd_n_cs_q <= xd[0];
            end
        end
    end

    assign n_nmi   = nmi_q ? 1'b0 : 1'bz;
    assign sd_n_cs = sd_n_cs_q;

    zx_spi_byte u_spi (
        .clk_i   (clk28),
        .rst_n_i (rst_n),
        .start_i (spi_start_s),
        .tx_i    (xd),
        .miso_i  (sd_miso),
        .busy_o  (spi_busy_s),
        .rx_o    (spi_rx_s),
        .sck_o   (sd_sck),
        .mosi_o  (sd_mosi)
    );

endmodule

// File: tb/tb_zx_ula_core.sv
// Bench for zx_ula_core: acts as Z80 + SRAM, compares against a behavioural model of
// paging, port map, SPI loopback, magic NMI and frame timing (shortened frame parameters).
module tb_zx_ula_core;

    localparam int H = 16, V = 8, IL = 5, ILEN = 4;

    logic        clk28 = 1'b0;
    logic        rst_n;
    logic        clkcpu;
    logic [15:0] xa;
    wire  [7:0]  xd;
    wire  [7:0]  vd;
    wire         n_nmi;
    logic        n_rd, n_wr, n_iorqge, n_mreq, n_m1, n_rfsh;
    logic        n_romcs, n_vrd, n_vwr, n_int;
    logic [17:14] ra;
    logic [18:0] va;
    logic        n_magic, tape_in, n_joy_b2, sd_cd;
    logic [4:0]  kd;
    logic        sd_mosi, sd_miso, sd_sck, sd_n_cs;

    logic [7:0]  xd_drv;
    logic        xd_oe;
    logic [7:0]  sram [0:524287];

    int tests = 0;
    int fails = 0;

    int m_bank, m_rom, m_lock, m_map;
    logic [7:0] model_mem [int];

    always #5 clk28 = ~clk28;

    assign xd      = xd_oe ? xd_drv : 8'hzz;
    assign vd      = n_vrd ? 8'hzz : sram[va];
    assign sd_miso = sd_mosi;
    pullup (n_nmi);

    always @(negedge clk28) if (!n_vwr) sram[va] <= vd;

    zx_ula_core #(.H_TSTATES(H), .V_LINES(V), .INT_LINE(IL), .INT_LEN(ILEN)) dut (
        .clk28(clk28), .rst_n(rst_n), .clkcpu(clkcpu), .xa(xa), .xd(xd),
        .n_rd(n_rd), .n_wr(n_wr), .n_iorqge(n_iorqge), .n_mreq(n_mreq), .n_m1(n_m1),
        .n_rfsh(n_rfsh), .n_romcs(n_romcs), .ra(ra), .va(va), .vd(vd), .n_vrd(n_vrd),
        .n_vwr(n_vwr), .n_int(n_int), .n_nmi(n_nmi), .n_magic(n_magic), .tape_in(tape_in),
        .kd(kd), .n_joy_b2(n_joy_b2), .sd_cd(sd_cd), .sd_mosi(sd_mosi), .sd_miso(sd_miso),
        .sd_sck(sd_sck), .sd_n_cs(sd_n_cs)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int exp_va(input int a);
        int seg, page;
        seg  = a / 16384;
        page = (seg == 1) ? 5 : (seg == 2) ? 2 : m_bank;
        return page * 16384 + (a % 16384);
    endfunction

    function automatic logic exp_nint(input int n);
        int f;
        f = (n / 8) % (H * V);
        return !((f / H == IL) && (f % H < ILEN));
    endfunction

    task automatic model_reset();
        m_bank = 0; m_rom = 0; m_lock = 0; m_map = 0;
    endtask

    task automatic mem_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk28);
        xa = a; xd_drv = d; xd_oe = 1'b1; n_mreq = 1'b0; n_wr = 1'b0;
        @(negedge clk28);
        check("wr_n_vwr", n_vwr, (a < 16'h4000) ? 1 : 0);
        if (a >= 16'h4000) begin
            check("wr_va", va, exp_va(a));
            check("wr_vd", vd, d);
            model_mem[exp_va(a)] = d;
        end
        @(negedge clk28);
        n_wr = 1'b1; n_mreq = 1'b1; xd_oe = 1'b0;
    endtask

    task automatic mem_read(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk28);
        xa = a; n_mreq = 1'b0; n_rd = 1'b0;
        @(negedge clk28);
        check("rd_n_romcs", n_romcs, (a < 16'h4000) ? 0 : 1);
        check("rd_n_vrd", n_vrd, (a < 16'h4000) ? 1 : 0);
        if (a < 16'h4000) check("rd_ra", ra, m_map * 2 + m_rom);
        else              check("rd_va", va, exp_va(a));
        d = xd;
        @(negedge clk28);
        n_rd = 1'b1; n_mreq = 1'b1;
    endtask

    task automatic io_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk28);
        xa = a; xd_drv = d; xd_oe = 1'b1; n_iorqge = 1'b0; n_wr = 1'b0;
        repeat (2) @(negedge clk28);
        n_wr = 1'b1; n_iorqge = 1'b1; xd_oe = 1'b0;
    endtask

    task automatic io_read(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk28);
        xa = a; n_iorqge = 1'b0; n_rd = 1'b0;
        @(negedge clk28);
        d = xd;
        n_rd = 1'b1; n_iorqge = 1'b1;
    endtask

    task automatic out_7ffd(input logic [7:0] v);
        io_write(16'h7FFD, v);
        if (m_lock == 0) begin
            m_bank = (v / 64) * 8 + (v % 8);
            m_rom  = (v / 16) % 2;
            m_lock = (v / 32) % 2;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d, b, v;
        logic [15:0] a;
        int lows;
        rst_n = 1'b0; xa = 16'h0000; xd_drv = 8'h00; xd_oe = 1'b0;
        n_rd = 1'b1; n_wr = 1'b1; n_iorqge = 1'b1; n_mreq = 1'b1; n_m1 = 1'b1; n_rfsh = 1'b1;
        n_magic = 1'b1; tape_in = 1'b0; kd = 5'h1F; n_joy_b2 = 1'b1; sd_cd = 1'b1;
        model_reset();
        repeat (3) @(negedge clk28);

        check("rst_clkcpu", clkcpu, 0);
        check("rst_n_int", n_int, 1);
        check("rst_n_nmi", n_nmi, 1);
        check("rst_n_romcs", n_romcs, 1);
        check("rst_n_vrd", n_vrd, 1);
        check("rst_n_vwr", n_vwr, 1);
        check("rst_sd_n_cs", sd_n_cs, 1);
        check("rst_sd_sck", sd_sck, 0);
        check("rst_sd_mosi", sd_mosi, 1);
        check("rst_ra", ra, 0);

        rst_n = 1'b1;
        lows = 0;
        for (int n = 1; n <= 2200; n++) begin
            @(negedge clk28);
            check("clkcpu_div", clkcpu, (n / 4) % 2);
            check("n_int_frame", n_int, exp_nint(n));
            if (!n_int) lows++;
        end
        check("int_low_total", lows, 2 * ILEN * 8);

        out_7ffd(8'h17);
        mem_write(16'hC000, 8'h5A);
        mem_read(16'hC000, d);
        check("c000_readback", d, 8'h5A);
        mem_read(16'h0000, d);
        mem_read(16'h4000, d);
        mem_write(16'h1234, 8'hEE);

        for (int i = 0; i < 20; i++) begin
            v = 8'($urandom) & 8'hDF;
            out_7ffd(v);
            a = 16'($urandom_range(16'h4000, 16'hFFFF));
            b = 8'($urandom);
            mem_write(a, b);
            mem_read(a, d);
            check("rand_readback", d, model_mem[exp_va(a)]);
            mem_read(16'($urandom_range(0, 16'h3FFF)), d);
        end

        out_7ffd(8'h20);
        out_7ffd(8'h07);
        mem_read(16'h0000, d);
        check("locked_ra14", ra[14], 0);
        mem_write(16'hC010, 8'h33);
        mem_read(16'hC010, d);
        check("locked_readback", d, 8'h33);

        for (int i = 0; i < 4; i++) begin
            kd = 5'($urandom); tape_in = 1'($urandom); n_joy_b2 = 1'($urandom); sd_cd = 1'($urandom);
            io_read(16'hFEFE, d);
            check("port_fe", d, 128 + tape_in * 64 + 32 + kd);
            io_read(16'h001F, d);
            check("port_1f", d, (1 - n_joy_b2) * 32);
            io_read(16'h0077, d);
            check("port_77_idle", d, 1 - sd_cd);
        end

        for (int i = 0; i < 5; i++) begin
            b = (i == 0) ? 8'hA5 : 8'($urandom);
            io_write(16'h0057, b);
            io_read(16'h0077, d);
            check("spi_busy", d, 2 + (1 - sd_cd));
            repeat (16) @(negedge clk28);
            io_read(16'h0057, d);
            check("spi_rx", d, b);
            io_read(16'h0077, d);
            check("spi_done", d, 1 - sd_cd);
        end
        io_write(16'h0057, 8'hA5);
        io_write(16'h0057, 8'h3C);
        repeat (16) @(negedge clk28);
        io_read(16'h0057, d);
        check("spi_busy_ignore", d, 8'hA5);
        io_write(16'h0077, 8'h00);
        check("sd_cs_low", sd_n_cs, 0);
        io_write(16'h0077, 8'h01);
        check("sd_cs_high", sd_n_cs, 1);

        n_magic = 1'b0;
        for (int k = 0; k < 20 && n_nmi !== 1'b0; k++) @(negedge clk28);
        check("nmi_assert", n_nmi, 0);
        repeat (100) @(negedge clk28);
        check("nmi_held", n_nmi, 0);
        @(negedge clk28);
        xa = 16'h0066; n_m1 = 1'b0; n_mreq = 1'b0; n_rd = 1'b0;
        repeat (2) @(negedge clk28);
        n_m1 = 1'b1; n_mreq = 1'b1; n_rd = 1'b1;
        m_map = 1;
        @(negedge clk28);
        check("nmi_release", n_nmi, 1);
        mem_read(16'h0100, d);
        repeat (50) @(negedge clk28);
        check("nmi_once", n_nmi, 1);
        n_magic = 1'b1;
        repeat (10) @(negedge clk28);
        n_magic = 1'b0;
        repeat (20) @(negedge clk28);
        check("nmi_mapped_ignore", n_nmi, 1);
        n_magic = 1'b1;
        io_write(16'h00F7, 8'h00);
        m_map = 0;
        mem_read(16'h0200, d);

        out_7ffd(8'h37);
        io_write(16'h0077, 8'h00);
        n_magic = 1'b0;
        repeat (10) @(negedge clk28);
        check("nmi_before_rst", n_nmi, 0);
        io_write(16'h0057, 8'h00);
        repeat (3) @(negedge clk28);
        rst_n = 1'b0;
        n_magic = 1'b1;
        model_reset();
        @(negedge clk28);
        check("mid_rst_sck", sd_sck, 0);
        check("mid_rst_mosi", sd_mosi, 1);
        check("mid_rst_cs", sd_n_cs, 1);
        check("mid_rst_nmi", n_nmi, 1);
        check("mid_rst_ra", ra, 0);
        rst_n = 1'b1;
        out_7ffd(8'h03);
        mem_write(16'hC123, 8'h77);
        mem_read(16'hC123, d);
        check("unlock_readback", d, 8'h77);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
